apb_master_arb: RTL

Two-requester APB master that owns the APB bus in front of `apb_slave` and shares it between two internal requesters. Each requester posts a single read or write command. The block arbitrates round-robin, runs the APB SETUP/ACCESS sequence including PREADY wait states, and returns read data and error status with a one-cycle completion pulse. It replaces hand-driven APB stimulus as the single bus master.

---
 rtl/apb_master_arb.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/apb_master_arb.sv
// apb_master_arb
// Two-requester APB master. Arbitrates two single-command requesters
// round-robin, runs the APB SETUP/ACCESS handshake with PREADY wait states
// and returns read data / error with a one-cycle completion pulse.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT consecutive PREADY-low cycles. The abort completes with rsp_err=1
// and rsp_rdata=0. Without the macro, ACCESS waits for PREADY indefinitely.

module apb_master_arb #(
    parameter int ADDRW   = 32,
    parameter int DATAW   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [1:0]       req,
    input  logic [ADDRW-1:0] req_addr0,
    input  logic [ADDRW-1:0] req_addr1,
    input  logic             req_write0,
    input  logic             req_write1,
    input  logic [DATAW-1:0] req_wdata0,
    input  logic [DATAW-1:0] req_wdata1,
    output logic [1:0]       done,
    output logic [DATAW-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [ADDRW-1:0] PADDR,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [DATAW-1:0] PWDATA,
    input  logic             PREADY,
    input  logic [DATAW-1:0] PRDATA,
    input  logic             PSLVERR
);

    // A zero TIMEOUT would make the abort counter meaningless.
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("apb_master_arb: TIMEOUT must be at least 1");
    end

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic             last_r;
    logic             last_s;
    logic             winner_r;
    logic             winner_s;
    logic             grant_s;
    logic [ADDRW-1:0] paddr_s;
    logic             psel_s;
    logic             penable_s;
    logic             pwrite_s;
    logic [DATAW-1:0] pwdata_s;
    logic [1:0]       done_s;
    logic [DATAW-1:0] rsp_rdata_s;
    logic             rsp_err_s;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic [TMO_W-1:0] tmo_cnt_s;
`endif

    // Round-robin pick: a lone requester wins, a tie goes to the one that was not granted last.
    always_comb begin
        grant_s = 1'b0;
        if (req[0] && req[1]) begin
            grant_s = ~last_r;
        end else if (req[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_s     = state_r;
        last_s      = last_r;
        winner_s    = winner_r;
        paddr_s     = PADDR;
        psel_s      = PSEL;
        penable_s   = PENABLE;
        pwrite_s    = PWRITE;
        pwdata_s    = PWDATA;
        done_s      = 2'b00;
        rsp_rdata_s = rsp_rdata;
        rsp_err_s   = rsp_err;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_cnt_s   = tmo_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_s   = ST_SETUP;
                    winner_s  = grant_s;
                    last_s    = grant_s;
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_cnt_s = {TMO_W{1'b0}};
`endif
                    if (grant_s) begin
                        paddr_s  = req_addr1;
                        pwrite_s = req_write1;
                        pwdata_s = req_wdata1;
                    end else begin
                        paddr_s  = req_addr0;
                        pwrite_s = req_write0;
                        pwdata_s = req_wdata0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s   = ST_ACCESS;
                psel_s    = 1'b1;
                penable_s = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_s     = ST_DONE;
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    done_s      = winner_r ? 2'b10 : 2'b01;
                    rsp_err_s   = PSLVERR;
                    if (PWRITE) begin
                        rsp_rdata_s = {DATAW{1'b0}};
                    end else begin
                        rsp_rdata_s = PRDATA;
                    end
                end else begin
`ifdef APB_ARB_TIMEOUT_EN
                    // PREADY has priority, so the limit only matters when the slave is still stalling.
                    if (tmo_cnt_r == TMO_LAST) begin
                        state_s     = ST_DONE;
                        psel_s      = 1'b0;
                        penable_s   = 1'b0;
                        done_s      = winner_r ? 2'b10 : 2'b01;
                        rsp_err_s   = 1'b1;
                        rsp_rdata_s = {DATAW{1'b0}};
                    end else begin
                        state_s   = ST_ACCESS;
                        tmo_cnt_s = tmo_cnt_r + TMO_ONE;
                    end
`else
                    state_s = ST_ACCESS;
`endif
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                done_s  = 2'b00;
            end
            default: begin
                state_s   = ST_IDLE;
                psel_s    = 1'b0;
                penable_s = 1'b0;
                done_s    = 2'b00;
            end
        endcase
    end

    // State and registered bus/response outputs; reset aborts any transfer immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r   <= ST_IDLE;
            last_r    <= 1'b1;
            winner_r  <= 1'b0;
            PADDR     <= {ADDRW{1'b0}};
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= {DATAW{1'b0}};
            done      <= 2'b00;
            rsp_rdata <= {DATAW{1'b0}};
            rsp_err   <= 1'b0;
        end else begin
            state_r   <= state_s;
            last_r    <= last_s;
            winner_r  <= winner_s;
            PADDR     <= paddr_s;
            PSEL      <= psel_s;
            PENABLE   <= penable_s;
            PWRITE    <= pwrite_s;
            PWDATA    <= pwdata_s;
            done      <= done_s;
            rsp_rdata <= rsp_rdata_s;
            rsp_err   <= rsp_err_s;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    // Consecutive PREADY-low ACCESS cycles of the current transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_s;
        end
    end
`endif

endmodule
